// File: rtl/key_arb_pkg.sv
// Shared types and helpers for the key_source_arbiter slice.
package key_arb_pkg;

    localparam int KEY_W_DFLT = 4;
    localparam int MAX_SRC    = 8;
    localparam int ID_W       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // Next round-robin start after a player gives up the bus; wraps back to 1, never to 0.
    function automatic logic [ID_W-1:0] rr_after(input logic [ID_W-1:0] owner,
                                                 input logic [ID_W-1:0] last_idx);
        logic [ID_W-1:0] nxt;
        if (owner >= last_idx) begin
            nxt = 3'd1;
        end else begin
            nxt = owner + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/key_source_arbiter_rr_pick.sv
// Combinational picker: requester 0 wins outright, players 1..N_SRC-1 are searched from ptr with wrap.
module rr_pick
    import key_arb_pkg::*;
#(
    parameter int N_SRC = 3
) (
    input  logic [N_SRC-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    logic found_s;

    // Two passes over the players: ptr..top first, then 1..ptr-1, so the search wraps.
    always_comb begin
        valid   = |req;
        idx     = 3'd0;
        found_s = req[0];
        for (int k = 1; k < N_SRC; k++) begin
            idx     = (!found_s && (k >= int'(ptr)) && req[k]) ? ID_W'(k) : idx;
            found_s = found_s | ((k >= int'(ptr)) && req[k]);
        end
        for (int k = 1; k < N_SRC; k++) begin
            idx     = (!found_s && (k < int'(ptr)) && req[k]) ? ID_W'(k) : idx;
            found_s = found_s | ((k < int'(ptr)) && req[k]);
        end
    end

endmodule

// File: rtl/key_source_arbiter.sv
// Shares one tone-generator input between the live keyboard (index 0, absolute priority) and
// round-robin song players, with a silent guard gap between owners. Define KEY_ARB_TIMEOUT_EN
// to bound a player's ownership to HOLD_MAX cycles while other players wait.
module key_source_arbiter
    import key_arb_pkg::*;
#(
    parameter int N_SRC    = 3,
    parameter int KEY_W    = KEY_W_DFLT,
    parameter int GAP_CYC  = 500000,
    parameter int HOLD_MAX = 500000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC*KEY_W-1:0] key_in,
    input  logic [N_SRC-1:0]       key_on_in,
    output logic [N_SRC-1:0]       grant,
    output logic [2:0]             owner_id,
    output logic                   busy,
    output logic [KEY_W-1:0]       key_out,
    output logic                   key_on_out
);

    localparam int              GAP_W    = $clog2(GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(N_SRC - 1);

    if (N_SRC < 2 || N_SRC > MAX_SRC || GAP_CYC < 1 || HOLD_MAX < 1) begin : g_bad_cfg
        $error("key_source_arbiter: unsupported parameter set");
    end

    arb_state_e         state_q, state_d;
    logic [N_SRC-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic               busy_q, busy_d;
    logic [KEY_W-1:0]   key_out_q, key_out_d;
    logic               key_on_q, key_on_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic               pick_valid_s;
    logic [ID_W-1:0]    pick_idx_s;
    logic [N_SRC-1:0]   pick_oh_s;
    logic [KEY_W-1:0]   key_sel_s;
    logic               key_on_sel_s;
    logic               owner_req_s;
    logic               preempt_s;
    logic               timeout_s;
    logic               leave_s;

    rr_pick #(
        .N_SRC (N_SRC)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Decode the pick to one-hot and mux the current owner's key lane.
    always_comb begin
        pick_oh_s    = '0;
        key_sel_s    = '0;
        key_on_sel_s = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            pick_oh_s[i] = (pick_idx_s == ID_W'(i));
            key_sel_s    = (owner_q == ID_W'(i)) ? key_in[i*KEY_W +: KEY_W] : key_sel_s;
            key_on_sel_s = (owner_q == ID_W'(i)) ? key_on_in[i] : key_on_sel_s;
        end
    end

    // grant_q is one-hot on the owner while in GRANT, so it doubles as the owner's req mask.
    assign owner_req_s = |(req & grant_q);
    assign preempt_s   = (owner_q != 3'd0) && req[0];
    assign leave_s     = !owner_req_s || preempt_s || timeout_s;

`ifdef KEY_ARB_TIMEOUT_EN
    localparam int               HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              others_wait_s;

    assign others_wait_s = |(req[N_SRC-1:1] & ~grant_q[N_SRC-1:1]);
    assign timeout_s     = (owner_q != 3'd0) && (hold_cnt_q == HOLD_LIM) && others_wait_s;

    // Hold counter: cleared on each new ownership, saturates at the limit.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_d == GRANT && state_q != GRANT) begin
            hold_cnt_d = '0;
        end else if (state_q == GRANT && state_d == GRANT && owner_q != 3'd0 &&
                     hold_cnt_q != HOLD_LIM) begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Arbiter FSM: arbitrate from IDLE or on the last gap cycle, serve the owner, then go silent.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        key_out_d = key_out_q;
        key_on_d  = key_on_q;
        rr_ptr_d  = rr_ptr_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE, GAP: begin
                if (state_q == GAP && gap_cnt_q != GAP_LAST) begin
                    gap_cnt_d = gap_cnt_q + GAP_ONE;
                end else if (pick_valid_s) begin
                    state_d  = GRANT;
                    grant_d  = pick_oh_s;
                    owner_d  = pick_idx_s;
                    busy_d   = 1'b1;
                    key_on_d = 1'b0;
                end else begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    key_on_d = 1'b0;
                end
            end
            GRANT: begin
                if (leave_s) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    busy_d    = 1'b1;
                    key_on_d  = 1'b0;
                    gap_cnt_d = '0;
                    rr_ptr_d  = (owner_q == 3'd0) ? rr_ptr_q : rr_after(owner_q, LAST_IDX);
                end else begin
                    key_out_d = key_sel_s;
                    key_on_d  = key_on_sel_s;
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                busy_d   = 1'b0;
                key_on_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset silences the tone generator immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= 3'd0;
            busy_q    <= 1'b0;
            key_out_q <= '0;
            key_on_q  <= 1'b0;
            rr_ptr_q  <= 3'd1;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            key_out_q <= key_out_d;
            key_on_q  <= key_on_d;
            rr_ptr_q  <= rr_ptr_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign grant      = grant_q;
    assign owner_id   = owner_q;
    assign busy       = busy_q;
    assign key_out    = key_out_q;
    assign key_on_out = key_on_q;

endmodule

// File: tb/tb_key_source_arbiter.sv
// Randomized bench for key_source_arbiter against a phase-level reference model of the arbiter.
module tb_key_source_arbiter;

    localparam int N_SRC    = 3;
    localparam int KEY_W    = 4;
    localparam int GAP_CYC  = 8;
    localparam int HOLD_MAX = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [11:0] key_in = 12'h000;
    logic [2:0]  key_on_in = 3'b000;
    logic [2:0]  grant;
    logic [2:0]  owner_id;
    logic        busy;
    logic [3:0]  key_out;
    logic        key_on_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 = nobody, 1 = someone owns, 2 = silent gap.
    int         m_phase, m_owner, m_ptr, m_left, m_held;
    logic [3:0] m_key;
    logic       m_on;

    key_source_arbiter #(
        .N_SRC(N_SRC), .KEY_W(KEY_W), .GAP_CYC(GAP_CYC), .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .key_in(key_in), .key_on_in(key_on_in),
        .grant(grant), .owner_id(owner_id), .busy(busy), .key_out(key_out),
        .key_on_out(key_on_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int choose(input logic [2:0] r, input int ptr);
        if (r[0]) return 0;
        for (int s = 0; s < N_SRC - 1; s++) begin
            int k;
            k = 1 + ((ptr - 1 + s) % (N_SRC - 1));
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_ptr = 1; m_left = 0; m_held = 0;
        m_key = 4'd0; m_on = 1'b0;
    endtask

    task automatic model_step();
        int   c;
        logic leave;
        case (m_phase)
            0: begin
                c = choose(req, m_ptr);
                if (c >= 0) begin m_phase = 1; m_owner = c; m_held = 0; end
            end
            1: begin
                leave = !req[m_owner] || (m_owner != 0 && req[0]);
`ifdef KEY_ARB_TIMEOUT_EN
                if (m_owner != 0 && m_held >= HOLD_MAX &&
                    ((req & ~(3'b001 << m_owner) & 3'b110) != 3'b000)) leave = 1'b1;
`endif
                if (leave) begin
                    m_phase = 2; m_left = GAP_CYC; m_on = 1'b0;
                    if (m_owner != 0) m_ptr = (m_owner == N_SRC - 1) ? 1 : m_owner + 1;
                end else begin
                    m_key = key_in[m_owner*KEY_W +: KEY_W];
                    m_on  = key_on_in[m_owner];
                    m_held++;
                end
            end
            2: begin
                m_left--;
                if (m_left == 0) begin
                    c = choose(req, m_ptr);
                    if (c >= 0) begin m_phase = 1; m_owner = c; m_held = 0; end
                    else m_phase = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_outputs();
        chk("grant", grant, (m_phase == 1) ? (3'b001 << m_owner) : 3'b000);
        chk("owner_id", owner_id, m_owner);
        chk("busy", busy, m_phase != 0);
        chk("key_out", key_out, m_key);
        chk("key_on_out", key_on_out, m_on);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_outputs();
    endtask

    task automatic settle();
        req = 3'b000;
        repeat (GAP_CYC + 4) step();
    endtask

    logic [2:0] prev_g;
    logic [2:0] seq[$];
    logic [2:0] rr_exp[3];
    int         busy_cnt, events, m_events, changes, pm;

    initial begin
        model_reset();
        // Reset holds everything silent even with all requests up.
        req = 3'b111; key_in = 12'hABC; key_on_in = 3'b111;
        repeat (3) begin
            step();
            chk("rst_grant", grant, 3'b000);
            chk("rst_keyon", key_on_out, 1'b0);
        end
        rst_n = 1'b1;
        step(); step();
        chk("rst_release_grant", grant, 3'b001);
        settle();

        // Single player.
        req = 3'b010; key_in = 12'h020; key_on_in = 3'b010;
        step();
        chk("sp_grant", grant, 3'b010);
        chk("sp_keyon_entry", key_on_out, 1'b0);
        step();
        chk("sp_key", key_out, 4'd2);
        chk("sp_keyon", key_on_out, 1'b1);
        req = 3'b000;
        step();
        chk("sp_release_keyon", key_on_out, 1'b0);
        chk("sp_release_busy", busy, 1'b1);
        busy_cnt = 1;
        for (int i = 0; i < GAP_CYC + 4; i++) begin
            step();
            if (!busy) break;
            busy_cnt++;
        end
        chk("sp_gap_len", busy_cnt, GAP_CYC);

        // Preemption by the live keyboard.
        req = 3'b010; key_on_in = 3'b010;
        step();
        chk("pre_grant1", grant, 3'b010);
        repeat (4) step();
        req = 3'b011;
        for (int i = 0; i < GAP_CYC; i++) begin
            step();
            chk("pre_silent_grant", grant, 3'b000);
            chk("pre_silent_keyon", key_on_out, 1'b0);
        end
        step();
        chk("pre_grant0", grant, 3'b001);
        repeat (5) step();
        chk("pre_hold0", grant, 3'b001);
        req = 3'b010;
        repeat (GAP_CYC + 1) step();
        chk("pre_regain", grant, 3'b010);
        settle();

        // Mid-operation reset while a note sounds; pointer was left at 2 by the last release.
        req = 3'b010; key_in = 12'h050; key_on_in = 3'b010;
        repeat (3) step();
        chk("mid_keyon_before", key_on_out, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_keyon", key_on_out, 1'b0);
        chk("mid_rst_grant", grant, 3'b000);
        chk("mid_rst_busy", busy, 1'b0);
        model_reset();
        req = 3'b110;
        step(); step();
        #2;
        rst_n = 1'b1;

        // Round-robin: both players held, each gives up after 10 cycles of ownership.
        rr_exp[0] = 3'b010; rr_exp[1] = 3'b100; rr_exp[2] = 3'b010;
        for (int c = 0; c < 200 && seq.size() < 3; c++) begin
            req = (m_phase == 1 && m_owner != 0 && m_held >= 10) ?
                  (3'b110 & ~(3'b001 << m_owner)) : 3'b110;
            key_in = 12'($urandom); key_on_in = 3'($urandom);
            prev_g = grant;
            step();
            if (grant != 3'b000 && prev_g == 3'b000) seq.push_back(grant);
        end
        chk("rr_count", seq.size(), 3);
        for (int i = 0; i < seq.size() && i < 3; i++) chk("rr_seq", seq[i], rr_exp[i]);
        settle();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if (($urandom % 40) == 0) req[0] = ~req[0];
            if (($urandom % 12) == 0) req[1] = ~req[1];
            if (($urandom % 12) == 0) req[2] = ~req[2];
            key_in = 12'($urandom); key_on_in = 3'($urandom);
            step();
        end
        settle();

        // Long contention between the two players.
        events = 0; m_events = 0;
        req = 3'b110;
        for (int c = 0; c < 400; c++) begin
            key_in = 12'($urandom); key_on_in = 3'($urandom);
            prev_g = grant; pm = m_phase;
            step();
            if (grant != 3'b000 && prev_g == 3'b000) events++;
            if (m_phase == 1 && pm != 1) m_events++;
        end
        chk("to_grant_events", events, m_events);
`ifdef KEY_ARB_TIMEOUT_EN
        chk("to_switched", events > 1, 1'b1);
`else
        chk("to_no_switch", events, 1);
`endif

        // Lone player keeps the bus.
        req = 3'b010;
        repeat (30) step();
        changes = 0;
        for (int c = 0; c < 300; c++) begin
            key_in = 12'($urandom); key_on_in = 3'($urandom);
            prev_g = grant;
            step();
            if (grant != prev_g) changes++;
        end
        chk("solo_no_switch", changes, 0);
        chk("solo_grant", grant, 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
